// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcode keys, ALU/jump codes, control word and FSM states
//               shared by the ID-stage decoder and the ID/EX pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcode keys are inst[6:2]
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_FENCE  = 5'b00011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [1:0] jump;
        logic       auipc;
        logic       jal;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational opcode decoder producing the control word and
//               source-register usage flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl     = CTRL_NOP;
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        o_illegal  = 1'b0;
        if (i_opcode[1:0] != 2'b11) begin
            o_illegal = 1'b1;
        end else begin
            case (i_opcode[6:2])
                OP_R: begin
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = ALU_FN;
                    o_uses_rs1      = 1'b1;
                    o_uses_rs2      = 1'b1;
                end
                OP_IMM: begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = ALU_FN;
                    o_uses_rs1      = 1'b1;
                end
                OP_LOAD: begin
                    o_ctrl.memread  = 1'b1;
                    o_ctrl.memtoreg = 1'b1;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = ALU_ADD;
                    o_uses_rs1      = 1'b1;
                end
                OP_STORE: begin
                    o_ctrl.memwrite = 1'b1;
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.aluop    = ALU_ADD;
                    o_uses_rs1      = 1'b1;
                    o_uses_rs2      = 1'b1;
                end
                OP_LUI: begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = ALU_LUI;
                end
                OP_BRANCH: begin
                    o_ctrl.aluop  = ALU_BR;
                    o_ctrl.branch = 1'b1;
                    o_uses_rs1    = 1'b1;
                    o_uses_rs2    = 1'b1;
                end
                OP_AUIPC: begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.aluop    = ALU_FN;
                    o_ctrl.auipc    = 1'b1;
                end
                OP_JAL: begin
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.jump     = JMP_JAL;
                    o_ctrl.jal      = 1'b1;
                end
                OP_JALR: begin
                    o_ctrl.alusrc   = 1'b1;
                    o_ctrl.regwrite = 1'b1;
                    o_ctrl.jump     = JMP_JALR;
                    o_ctrl.jal      = 1'b1;
                    o_uses_rs1      = 1'b1;
                end
                OP_FENCE, OP_SYSTEM: begin
                    o_ctrl = CTRL_NOP;
                end
                default: begin
                    o_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode_pipe
// Description : ID-stage decode with ID/EX control register, load-use stall,
//               branch flush, sticky SYSTEM halt and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int N         = 32,
    parameter int CNT_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [N-1:0]     inst,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_illegal,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_auipc,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic [1:0]       ex_aluop,
    output logic [1:0]       ex_jump,
    output logic [4:0]       ex_rd,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    ctrl_t             w_dec_ctrl;
    logic              w_uses_rs1;
    logic              w_uses_rs2;
    logic              w_illegal;
    logic              w_is_system;
    logic              w_hazard;
    logic              w_run;
    logic              w_load;
    logic              w_unused_inst;
    state_t            r_state;
    state_t            w_state_next;
    ctrl_t             r_ctrl;
    ctrl_t             w_ctrl_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_illegal;
    logic              w_illegal_next;
    logic [4:0]        r_rd;
    logic [4:0]        w_rd_next;
    logic [CNT_W-1:0]  r_stall_cnt;

    ctrl_decode u_decode (
        .i_opcode   (inst[6:0]),
        .o_ctrl     (w_dec_ctrl),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2),
        .o_illegal  (w_illegal)
    );

    assign w_unused_inst = ^{inst[N-1:25], inst[14:12]};
    assign w_is_system   = !w_illegal && (inst[6:2] == OP_SYSTEM);

    // Only a load already in EX can create a hazard; r_rd is zero for non-writers
    assign w_hazard = HAZARD_EN && id_valid && r_valid && r_ctrl.memread
                      && (r_rd != 5'd0)
                      && ((w_uses_rs1 && (inst[19:15] == r_rd))
                          || (w_uses_rs2 && (inst[24:20] == r_rd)));

    assign w_run  = (r_state == ST_RUN);
    assign stall  = (w_run && w_hazard && !flush) || !w_run;
    assign w_load = w_run && !flush && !w_hazard && id_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_load && w_is_system) w_state_next = ST_HALT;
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_ctrl_next    = CTRL_NOP;
        w_valid_next   = 1'b0;
        w_illegal_next = 1'b0;
        w_rd_next      = 5'd0;
        if (w_load) begin
            w_ctrl_next    = w_dec_ctrl;
            w_valid_next   = 1'b1;
            w_illegal_next = w_illegal;
            w_rd_next      = w_dec_ctrl.regwrite ? inst[11:7] : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl    <= CTRL_NOP;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_rd      <= 5'd0;
        end else begin
            r_ctrl    <= w_ctrl_next;
            r_valid   <= w_valid_next;
            r_illegal <= w_illegal_next;
            r_rd      <= w_rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_illegal  = r_illegal;
    assign ex_branch   = r_ctrl.branch;
    assign ex_jal      = r_ctrl.jal;
    assign ex_auipc    = r_ctrl.auipc;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_aluop    = r_ctrl.aluop;
    assign ex_jump     = r_ctrl.jump;
    assign ex_rd       = r_rd;
    assign halted      = (r_state == ST_HALT);
    assign stall_cnt   = r_stall_cnt;

endmodule : ctrl_decode_pipe
`default_nettype wire

// File: tb/tb_ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_decode_pipe
// Description : Directed self-checking bench; a second instance with a 2-bit
//               stall counter shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_decode_pipe;

    localparam logic [31:0] c_ADD3  = 32'h002081B3;
    localparam logic [31:0] c_LW5   = 32'h0000A283;
    localparam logic [31:0] c_ADD6  = 32'h00128333;
    localparam logic [31:0] c_ADDI6 = 32'h00508313;
    localparam logic [31:0] c_ECALL = 32'h00000073;
    localparam logic [31:0] c_BEQ   = 32'h00208063;
    localparam logic [31:0] c_JAL1  = 32'h004000EF;
    localparam logic [31:0] c_SW    = 32'h0020A223;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] inst;
    logic        flush;

    logic        stall, ex_valid, ex_illegal, ex_branch, ex_jal, ex_auipc;
    logic        ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop, ex_jump;
    logic [4:0]  ex_rd;
    logic        halted;
    logic [15:0] stall_cnt;

    logic        s_stall, s_valid, s_illegal, s_branch, s_jal, s_auipc;
    logic        s_memread, s_memtoreg, s_memwrite, s_alusrc, s_regwrite;
    logic [1:0]  s_aluop, s_jump;
    logic [4:0]  s_rd;
    logic        s_halted;
    logic [1:0]  s_stall_cnt;

    logic [18:0] w_ex;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .inst(inst), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_auipc(ex_auipc),
        .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
        .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
        .ex_jump(ex_jump), .ex_rd(ex_rd), .halted(halted), .stall_cnt(stall_cnt)
    );

    ctrl_decode_pipe #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .inst(inst), .flush(flush),
        .stall(s_stall), .ex_valid(s_valid), .ex_illegal(s_illegal),
        .ex_branch(s_branch), .ex_jal(s_jal), .ex_auipc(s_auipc),
        .ex_memread(s_memread), .ex_memtoreg(s_memtoreg), .ex_memwrite(s_memwrite),
        .ex_alusrc(s_alusrc), .ex_regwrite(s_regwrite), .ex_aluop(s_aluop),
        .ex_jump(s_jump), .ex_rd(s_rd), .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    assign w_ex = {ex_valid, ex_illegal, ex_memread, ex_memtoreg, ex_memwrite,
                   ex_alusrc, ex_regwrite, ex_aluop, ex_jump, ex_auipc, ex_jal,
                   ex_branch, ex_rd};

    // Expected ID/EX word in the same packing as w_ex
    function automatic logic [18:0] exw(
        input logic v, input logic il, input logic mr, input logic mtr,
        input logic mw, input logic as, input logic rw, input logic [1:0] aop,
        input logic [1:0] jp, input logic au, input logic jl, input logic br,
        input logic [4:0] rd);
        return {v, il, mr, mtr, mw, as, rw, aop, jp, au, jl, br, rd};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; inst = 32'h0; flush = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_ex",     32'(w_ex), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_cnt",    32'(stall_cnt), 32'h0);
        check("rst_stall",  32'(stall), 32'h0);

        id_valid = 1'b1; inst = c_ADD3;
        step();
        check("add3_ex",    32'(w_ex), 32'(exw(1,0,0,0,0,0,1,2'b10,2'b00,0,0,0,5'd3)));
        check("add3_stall", 32'(stall), 32'h0);

        // load-use: lw x5 then add x6,x5,x1
        inst = c_LW5;
        step();
        check("lw_ex", 32'(w_ex), 32'(exw(1,0,1,1,0,1,1,2'b00,2'b00,0,0,0,5'd5)));
        inst = c_ADD6;
        #1;
        check("hz_stall", 32'(stall), 32'h1);
        step();
        check("hz_bubble", 32'(w_ex), 32'h0);
        check("hz_cnt",    32'(stall_cnt), 32'h1);
        check("hz_unstall", 32'(stall), 32'h0);
        step();
        check("add6_ex", 32'(w_ex), 32'(exw(1,0,0,0,0,0,1,2'b10,2'b00,0,0,0,5'd6)));

        // addi's imm field equals x5 in the rs2 slot but rs2 is unused
        inst = c_LW5;
        step();
        inst = c_ADDI6;
        #1;
        check("addi_nohz", 32'(stall), 32'h0);
        step();
        check("addi_ex", 32'(w_ex), 32'(exw(1,0,0,0,0,1,1,2'b10,2'b00,0,0,0,5'd6)));

        // flush in the hazard cycle
        inst = c_LW5;
        step();
        inst = c_ADD6; flush = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 32'h0);
        step();
        check("fl_bubble", 32'(w_ex), 32'h0);
        check("fl_cnt",    32'(stall_cnt), 32'h1);

        // flush together with SYSTEM: no halt
        inst = c_ECALL;
        step();
        check("fl_sys_halt", 32'(halted), 32'h0);
        check("fl_sys_ex",   32'(w_ex), 32'h0);
        flush = 1'b0;

        inst = 32'h0;
        step();
        check("illegal_ex", 32'(w_ex), 32'(exw(1,1,0,0,0,0,0,2'b00,2'b00,0,0,0,5'd0)));
        inst = c_BEQ;
        step();
        check("beq_ex", 32'(w_ex), 32'(exw(1,0,0,0,0,0,0,2'b01,2'b00,0,0,1,5'd0)));
        inst = c_JAL1;
        step();
        check("jal_ex", 32'(w_ex), 32'(exw(1,0,0,0,0,0,1,2'b00,2'b01,0,1,0,5'd1)));
        inst = c_SW;
        step();
        check("sw_ex_rd0", 32'(w_ex), 32'(exw(1,0,0,0,1,1,0,2'b00,2'b00,0,0,0,5'd0)));

        inst = c_ECALL;
        step();
        check("ecall_ex",     32'(w_ex), 32'(exw(1,0,0,0,0,0,0,2'b00,2'b00,0,0,0,5'd0)));
        check("ecall_halted", 32'(halted), 32'h1);
        check("ecall_stall",  32'(stall), 32'h1);
        check("ecall_cnt",    32'(stall_cnt), 32'h1);
        inst = c_ADD3;
        for (int i = 0; i < 4; i++) begin
            step();
            check("halt_bubble", 32'(w_ex), 32'h0);
        end
        check("halt_held",  32'(halted), 32'h1);
        check("halt_cnt",   32'(stall_cnt), 32'd5);
        check("sat_cnt",    32'(s_stall_cnt), 32'd3);

        rst_n = 1'b0;
        step();
        check("rh_ex",     32'(w_ex), 32'h0);
        check("rh_halted", 32'(halted), 32'h0);
        check("rh_cnt",    32'(stall_cnt), 32'h0);
        check("rh_stall",  32'(stall), 32'h0);

        // reset asserted mid-stall
        rst_n = 1'b1; inst = c_LW5;
        step();
        inst = c_ADD6;
        #1;
        check("rs_stall_pre", 32'(stall), 32'h1);
        rst_n = 1'b0;
        step();
        check("rs_ex",    32'(w_ex), 32'h0);
        check("rs_cnt",   32'(stall_cnt), 32'h0);
        check("rs_stall", 32'(stall), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ctrl_decode_pipe
`default_nettype wire
